// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  // Arbiter FSM: IDLE accepts a request, BUSY waits out the memory latency.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Which port owns the access currently in flight.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // Deepest supported memory latency and the counter width that holds it.
  localparam int MEM_LAT_MAX = 4;
  localparam int LAT_W       = 3;

  localparam logic [LAT_W-1:0] LAT_ONE = 3'd1;

  // Latency counter load value; out-of-range parameters are clamped to 1..MEM_LAT_MAX.
  function automatic logic [LAT_W-1:0] lat_init(input int lat);
    logic [LAT_W-1:0] val;
    if (lat < 1) begin
      val = LAT_ONE;
    end else if (lat > MEM_LAT_MAX) begin
      val = LAT_W'(MEM_LAT_MAX);
    end else begin
      val = LAT_W'(lat);
    end
    return val;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, load/store port and unified-memory port.
// slave  : seen from the arbiter.
// master : seen from the core and memory around it.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // Instruction fetch port
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rdata;

  // Load/store port
  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rdata;

  // Unified memory port (word addressed)
  logic              mem_en;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-3:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req_valid, if_addr,
    output if_req_ready, if_rsp_valid, if_rdata,
    input  d_req_valid, d_we, d_be, d_addr, d_wdata,
    output d_req_ready, d_rsp_valid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req_valid, if_addr,
    input  if_req_ready, if_rsp_valid, if_rdata,
    output d_req_valid, d_we, d_be, d_addr, d_wdata,
    input  d_req_ready, d_rsp_valid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_arb_prio.sv
// Winner select between fetch and load/store. Data has priority, but after
// MAX_D_STREAK data grants in a row with fetch waiting, fetch gets one turn.
module arb_prio
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int STREAK_W     = $clog2(MAX_D_STREAK + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en_i,    // arbiter can accept a new access this cycle
  input  logic if_valid_i,
  input  logic d_valid_i,
  output logic grant_if_o,
  output logic grant_d_o
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1'b1);

  logic [STREAK_W-1:0] d_streak_q;
  logic [STREAK_W-1:0] d_streak_d;
  logic                if_starved_s;

  // Fetch is starved once data has won MAX_D_STREAK times in a row over it.
  assign if_starved_s = if_valid_i && (d_streak_q == STREAK_MAX);

  // Combinational winner select.
  always_comb begin
    grant_if_o = 1'b0;
    grant_d_o  = 1'b0;
    if (arb_en_i) begin
      if (d_valid_i && !if_starved_s) begin
        grant_d_o = 1'b1;
      end else if (if_valid_i) begin
        grant_if_o = 1'b1;
      end else begin
        grant_d_o = 1'b0;
      end
    end else begin
      grant_if_o = 1'b0;
    end
  end

  // Streak count: grows only while fetch is actually waiting, saturates at the limit.
  always_comb begin
    d_streak_d = d_streak_q;
    if (grant_if_o) begin
      d_streak_d = '0;
    end else if (grant_d_o) begin
      if (!if_valid_i) begin
        d_streak_d = '0;
      end else if (d_streak_q != STREAK_MAX) begin
        d_streak_d = d_streak_q + STREAK_ONE;
      end else begin
        d_streak_d = d_streak_q;
      end
    end else begin
      d_streak_d = d_streak_q;
    end
  end

  // Streak register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_streak_q <= '0;
    end else begin
      d_streak_q <= d_streak_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory between instruction fetch and load/store.
// One access in flight at a time; the response is routed back to its owner
// MEM_LAT cycles after the grant, and a new grant may issue in that same cycle.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int MAX_D_STREAK = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int                BE_W     = DATA_W / 8;
  localparam logic [LAT_W-1:0]  LAT_INIT = lat_init(MEM_LAT);

  state_e            state_q;
  owner_e            owner_q;
  logic              we_q;
  logic [LAT_W-1:0]  lat_cnt_q;

  logic              rsp_fire_s;
  logic              arb_en_s;
  logic              grant_if_s;
  logic              grant_d_s;
  logic              if_rsp_s;
  logic              d_rsp_s;

  logic              mem_en_s;
  logic              mem_we_s;
  logic [BE_W-1:0]   mem_be_s;
  logic [ADDR_W-3:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  // The response cycle is the last BUSY cycle; everything is squashed while in reset.
  assign rsp_fire_s = !rst && (state_q == BUSY) && (lat_cnt_q == LAT_ONE);
  assign arb_en_s   = !rst && ((state_q == IDLE) || rsp_fire_s);

  arb_prio #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_arb_prio (
    .clk        (clk),
    .rst        (rst),
    .arb_en_i   (arb_en_s),
    .if_valid_i (bus.if_req_valid),
    .d_valid_i  (bus.d_req_valid),
    .grant_if_o (grant_if_s),
    .grant_d_o  (grant_d_s)
  );

  assign if_rsp_s = rsp_fire_s && (owner_q == OWN_IF);
  assign d_rsp_s  = rsp_fire_s && (owner_q == OWN_D);

  assign bus.if_req_ready = grant_if_s;
  assign bus.d_req_ready  = grant_d_s;
  assign bus.if_rsp_valid = if_rsp_s;
  assign bus.d_rsp_valid  = d_rsp_s;

  // Read data is passed straight through to the owner; a store ack carries zero.
  assign bus.if_rdata = if_rsp_s ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.d_rdata  = (d_rsp_s && !we_q) ? bus.mem_rdata : {DATA_W{1'b0}};

  // Memory request mux: driven from the winner in its grant cycle, zero otherwise.
  always_comb begin
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_be_s    = {BE_W{1'b0}};
    mem_addr_s  = {(ADDR_W-2){1'b0}};
    mem_wdata_s = {DATA_W{1'b0}};
    if (grant_d_s) begin
      mem_en_s    = 1'b1;
      mem_we_s    = bus.d_we;
      mem_be_s    = bus.d_be;
      mem_addr_s  = bus.d_addr[ADDR_W-1:2];
      mem_wdata_s = bus.d_wdata;
    end else if (grant_if_s) begin
      mem_en_s   = 1'b1;
      mem_addr_s = bus.if_addr[ADDR_W-1:2];
    end else begin
      mem_en_s = 1'b0;
    end
  end

  assign bus.mem_en    = mem_en_s;
  assign bus.mem_we    = mem_we_s;
  assign bus.mem_be    = mem_be_s;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_wdata = mem_wdata_s;

  // Arbiter FSM: owner, store flag and latency countdown for the access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      we_q      <= 1'b0;
      lat_cnt_q <= '0;
    end else if (grant_if_s || grant_d_s) begin
      state_q   <= BUSY;
      owner_q   <= grant_d_s ? OWN_D : OWN_IF;
      we_q      <= grant_d_s & bus.d_we;
      lat_cnt_q <= LAT_INIT;
    end else begin
      case (state_q)
        IDLE: begin
          state_q   <= IDLE;
          lat_cnt_q <= '0;
        end
        BUSY: begin
          if (rsp_fire_s) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
          end else begin
            state_q   <= BUSY;
            lat_cnt_q <= lat_cnt_q - LAT_ONE;
          end
        end
        default: begin
          state_q   <= IDLE;
          lat_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (latency 1, 3 and 2) on one clock.
// Latency-1 instance runs a per-cycle vector table with a response scoreboard;
// the others cover back-to-back fetches and reset during an access.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic        clk;
  logic        rst;
  int unsigned cyc = 0;
  int          n_pass = 0;
  int          n_chk  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b2 ();

  // Memory read data carries a per-instance tag and the current cycle number.
  assign b1.mem_rdata = {8'hA1, cyc[23:0]};
  assign b3.mem_rdata = {8'hA3, cyc[23:0]};
  assign b2.mem_rdata = {8'hA2, cyc[23:0]};

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .MAX_D_STREAK(4))
    u_dut1 (.clk(clk), .rst(rst), .bus(b1));
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .MAX_D_STREAK(4))
    u_dut3 (.clk(clk), .rst(rst), .bus(b3));
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2), .MAX_D_STREAK(4))
    u_dut2 (.clk(clk), .rst(rst), .bus(b2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- scoreboard for the latency-1 instance ----------------
  typedef struct {
    logic        we;
    int unsigned due;
  } exp_t;

  exp_t if_q[$];
  exp_t d_q[$];

  // Every cycle: the response pulse must match the queue head's due cycle.
  always @(negedge clk) begin : mon1
    logic ev;
    exp_t e;
    if (!rst) begin
      ev = (if_q.size() != 0) && (if_q[0].due == cyc);
      chk("if_rsp_valid", b1.if_rsp_valid, ev);
      if (ev) begin
        e = if_q.pop_front();
        chk("if_rdata", b1.if_rdata, {8'hA1, cyc[23:0]});
      end
      ev = (d_q.size() != 0) && (d_q[0].due == cyc);
      chk("d_rsp_valid", b1.d_rsp_valid, ev);
      if (ev) begin
        e = d_q.pop_front();
        chk("d_rdata", b1.d_rdata, e.we ? 64'h0 : {32'h0, 8'hA1, cyc[23:0]});
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        if_v;
    logic [31:0] if_a;
    logic        d_v;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_a;
    logic [31:0] d_wd;
    logic        e_if;
    logic        e_d;
    logic        e_en;
    logic        e_we;
    logic [3:0]  e_be;
    logic [29:0] e_addr;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t row(input logic if_v, input logic [31:0] if_a,
                               input logic d_v, input logic d_we, input logic [3:0] d_be,
                               input logic [31:0] d_a, input logic [31:0] d_wd,
                               input logic e_if, input logic e_d, input logic [29:0] e_addr);
    vec_t r;
    r.if_v = if_v;  r.if_a = if_a;
    r.d_v  = d_v;   r.d_we = d_we; r.d_be = d_be; r.d_a = d_a; r.d_wd = d_wd;
    r.e_if = e_if;  r.e_d  = e_d;  r.e_addr = e_addr;
    r.e_en = e_if | e_d;
    r.e_we = e_d & d_we;
    r.e_be = e_d ? d_be : 4'h0;
    r.e_wd = e_d ? d_wd : 32'h0;
    return r;
  endfunction

  task automatic drive_idle_all();
    b1.if_req_valid = 1'b0; b1.if_addr = 32'h0; b1.d_req_valid = 1'b0; b1.d_we = 1'b0;
    b1.d_be = 4'h0; b1.d_addr = 32'h0; b1.d_wdata = 32'h0;
    b3.if_req_valid = 1'b0; b3.if_addr = 32'h0; b3.d_req_valid = 1'b0; b3.d_we = 1'b0;
    b3.d_be = 4'h0; b3.d_addr = 32'h0; b3.d_wdata = 32'h0;
    b2.if_req_valid = 1'b0; b2.if_addr = 32'h0; b2.d_req_valid = 1'b0; b2.d_we = 1'b0;
    b2.d_be = 4'h0; b2.d_addr = 32'h0; b2.d_wdata = 32'h0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    // Table: one row per clock, latency 1, streak limit 4.
    vt.push_back(row(1'b0, 32'h0,  1'b0, 1'b0, 4'h0,    32'h0,  32'h0,        1'b0, 1'b0, 30'h0));
    vt.push_back(row(1'b1, 32'h10, 1'b0, 1'b0, 4'h0,    32'h0,  32'h0,        1'b1, 1'b0, 30'h4));
    vt.push_back(row(1'b0, 32'h0,  1'b0, 1'b0, 4'h0,    32'h0,  32'h0,        1'b0, 1'b0, 30'h0));
    vt.push_back(row(1'b0, 32'h0,  1'b1, 1'b1, 4'b0011, 32'h20, 32'hAABBCCDD, 1'b0, 1'b1, 30'h8));
    vt.push_back(row(1'b0, 32'h0,  1'b1, 1'b0, 4'hF,    32'h20, 32'h0,        1'b0, 1'b1, 30'h8));
    vt.push_back(row(1'b1, 32'h44, 1'b0, 1'b0, 4'h0,    32'h0,  32'h0,        1'b1, 1'b0, 30'h11));
    vt.push_back(row(1'b0, 32'h0,  1'b1, 1'b0, 4'hF,    32'h30, 32'h0,        1'b0, 1'b1, 30'hC));
    vt.push_back(row(1'b0, 32'h0,  1'b0, 1'b0, 4'h0,    32'h0,  32'h0,        1'b0, 1'b0, 30'h0));
    vt.push_back(row(1'b0, 32'h0,  1'b0, 1'b0, 4'h0,    32'h0,  32'h0,        1'b0, 1'b0, 30'h0));
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 4; k++)
        vt.push_back(row(1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 1'b0, 1'b1, 30'h80));
      vt.push_back(row(1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 1'b1, 1'b0, 30'h40));
    end
    vt.push_back(row(1'b0, 32'h0,  1'b0, 1'b0, 4'h0,    32'h0,  32'h0,        1'b0, 1'b0, 30'h0));
    vt.push_back(row(1'b0, 32'h0,  1'b0, 1'b0, 4'h0,    32'h0,  32'h0,        1'b0, 1'b0, 30'h0));

    // Reset: with both valids high, nothing may be granted or driven.
    drive_idle_all();
    rst = 1'b1;
    b1.if_req_valid = 1'b1;
    b1.d_req_valid  = 1'b1;
    b1.if_addr      = 32'h10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_if_ready", b1.if_req_ready, 1'b0);
    chk("rst_d_ready",  b1.d_req_ready,  1'b0);
    chk("rst_mem_en",   b1.mem_en,       1'b0);
    chk("rst_mem_we",   b1.mem_we,       1'b0);
    chk("rst_mem_addr", b1.mem_addr,     30'h0);
    chk("rst_if_rsp",   b1.if_rsp_valid, 1'b0);
    chk("rst_d_rsp",    b1.d_rsp_valid,  1'b0);
    chk("rst_if_rdata", b1.if_rdata,     32'h0);
    @(posedge clk); #1;
    drive_idle_all();
    rst = 1'b0;

    // Table-driven run on the latency-1 instance.
    foreach (vt[i]) begin
      @(posedge clk); #1;
      b1.if_req_valid = vt[i].if_v;  b1.if_addr = vt[i].if_a;
      b1.d_req_valid  = vt[i].d_v;   b1.d_we    = vt[i].d_we;
      b1.d_be         = vt[i].d_be;  b1.d_addr  = vt[i].d_a;
      b1.d_wdata      = vt[i].d_wd;
      @(negedge clk);
      chk("vec_if_ready",  b1.if_req_ready, vt[i].e_if);
      chk("vec_d_ready",   b1.d_req_ready,  vt[i].e_d);
      chk("vec_mem_en",    b1.mem_en,       vt[i].e_en);
      chk("vec_mem_we",    b1.mem_we,       vt[i].e_we);
      chk("vec_mem_be",    b1.mem_be,       vt[i].e_be);
      chk("vec_mem_addr",  b1.mem_addr,     vt[i].e_addr);
      chk("vec_mem_wdata", b1.mem_wdata,    vt[i].e_wd);
      if (vt[i].e_if) if_q.push_back('{we: 1'b0, due: cyc + 1});
      if (vt[i].e_d)  d_q.push_back('{we: vt[i].d_we, due: cyc + 1});
    end
    @(posedge clk); #1;
    drive_idle_all();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_if_drained", if_q.size(), 0);
    chk("sb_d_drained",  d_q.size(),  0);

    // Latency 3: fetch held valid gives grants at 0,3,6 and responses at 3,6,9.
    @(posedge clk); #1;
    b3.if_req_valid = 1'b1;
    b3.if_addr      = 32'h40;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (k == 7) b3.if_req_valid = 1'b0;
      end
      @(negedge clk);
      chk("l3_if_ready", b3.if_req_ready, (k % 3 == 0) && (k <= 6));
      chk("l3_mem_en",   b3.mem_en,       (k % 3 == 0) && (k <= 6));
      chk("l3_if_rsp",   b3.if_rsp_valid, (k % 3 == 0) && (k >= 3));
      chk("l3_d_ready",  b3.d_req_ready,  1'b0);
      if ((k % 3 == 0) && (k >= 3)) chk("l3_if_rdata", b3.if_rdata, {8'hA3, cyc[23:0]});
    end

    // Latency 2: reset one cycle after a grant drops the in-flight response.
    @(posedge clk); #1;
    b2.if_req_valid = 1'b1;
    b2.if_addr      = 32'h80;
    @(negedge clk);
    chk("r2_grant",    b2.if_req_ready, 1'b1);
    chk("r2_mem_addr", b2.mem_addr,     30'h20);
    @(posedge clk); #1;
    b2.if_req_valid = 1'b0;
    b2.d_req_valid  = 1'b1;
    b2.d_addr       = 32'h84;
    b2.d_be         = 4'hF;
    rst = 1'b1;
    #1;
    chk("r2_rst_d_ready",  b2.d_req_ready,  1'b0);
    chk("r2_rst_if_ready", b2.if_req_ready, 1'b0);
    chk("r2_rst_mem_en",   b2.mem_en,       1'b0);
    chk("r2_rst_mem_addr", b2.mem_addr,     30'h0);
    chk("r2_rst_mem_be",   b2.mem_be,       4'h0);
    chk("r2_rst_d_rdata",  b2.d_rdata,      32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("r2_rst_if_rsp",   b2.if_rsp_valid, 1'b0);
    @(posedge clk); #1;
    b2.d_req_valid = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("r2_post_if_rsp", b2.if_rsp_valid, 1'b0);
      chk("r2_post_d_rsp",  b2.d_rsp_valid,  1'b0);
      @(posedge clk); #1;
    end
    b2.d_req_valid = 1'b1;
    b2.d_we        = 1'b0;
    b2.d_addr      = 32'h88;
    @(negedge clk);
    chk("r2_idle_grant",   b2.d_req_ready, 1'b1);
    chk("r2_idle_addr",    b2.mem_addr,    30'h22);
    @(posedge clk); #1;
    b2.d_req_valid = 1'b0;
    @(negedge clk);
    chk("r2_busy_d_rsp",   b2.d_rsp_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("r2_d_rsp",        b2.d_rsp_valid,  1'b1);
    chk("r2_d_rdata",      b2.d_rdata,      {8'hA2, cyc[23:0]});
    chk("r2_no_if_rsp",    b2.if_rsp_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
